riscv_core_mem_arbiter: RTL

//  Shares the single AXI-facing memory port between the icache refill path and the dcache
//  (block refill reads and write-through stores). One transaction in flight at a time; requests
//  are granted, latched and forwarded to memory, and the completion is routed back to the owner.

---
 rtl/riscv_core_mem_arbiter_pkg.sv | 25 ++
 rtl/riscv_core_mem_arbiter_if.sv | 66 ++++++
 rtl/riscv_core_mem_arbiter_select.sv | 41 ++++
 rtl/riscv_core_mem_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/riscv_core_mem_arbiter_pkg.sv
// rtl/riscv_core_mem_arbiter_pkg.sv - shared types and widths for the icache/dcache memory arbiter
package riscv_core_mem_arb_pkg;

    localparam int ADDR_WIDTH      = 64;
    localparam int CORE_DATA_WIDTH = 64;
    localparam int AXI_DATA_WIDTH  = 256;
    localparam int STRB_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IC = 2'd1,
        RD_DC = 2'd2,
        WR_DC = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_e;

    function automatic logic is_read(arb_state_e s);
        return (s == RD_IC) || (s == RD_DC);
    endfunction

endpackage

// File: rtl/riscv_core_mem_arbiter_if.sv
// rtl/riscv_core_mem_arbiter_if.sv - cache-side and memory-side signals of the memory arbiter
interface riscv_core_mem_arbiter_if
    import riscv_core_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256
);
    logic                       i_ic_read_req;
    logic [ADDR_WIDTH-1:0]      i_ic_read_address;
    logic                       o_ic_read_done;
    logic [AXI_DATA_WIDTH-1:0]  o_ic_block;

    logic                       i_dc_read_req;
    logic [ADDR_WIDTH-1:0]      i_dc_read_address;
    logic                       o_dc_read_done;
    logic [AXI_DATA_WIDTH-1:0]  o_dc_block;

    logic                       i_dc_write_valid;
    logic [ADDR_WIDTH-1:0]      i_dc_write_address;
    logic [CORE_DATA_WIDTH-1:0] i_dc_write_data;
    logic [STRB_WIDTH-1:0]      i_dc_write_strobe;
    logic                       o_dc_write_done;

    logic                       o_mem_read_req;
    logic [ADDR_WIDTH-1:0]      o_mem_read_address;
    logic                       i_mem_read_done;
    logic [AXI_DATA_WIDTH-1:0]  i_mem_block;
    logic                       o_mem_write_valid;
    logic [ADDR_WIDTH-1:0]      o_mem_write_address;
    logic [CORE_DATA_WIDTH-1:0] o_mem_write_data;
    logic [STRB_WIDTH-1:0]      o_mem_write_strobe;
    logic                       i_mem_write_done;

    logic                       o_busy;

    // master: the arbiter itself; slave: caches and AXI master around it
    modport master (
        input  i_ic_read_req, i_ic_read_address,
        output o_ic_read_done, o_ic_block,
        input  i_dc_read_req, i_dc_read_address,
        output o_dc_read_done, o_dc_block,
        input  i_dc_write_valid, i_dc_write_address, i_dc_write_data, i_dc_write_strobe,
        output o_dc_write_done,
        output o_mem_read_req, o_mem_read_address,
        input  i_mem_read_done, i_mem_block,
        output o_mem_write_valid, o_mem_write_address, o_mem_write_data, o_mem_write_strobe,
        input  i_mem_write_done,
        output o_busy
    );

    modport slave (
        output i_ic_read_req, i_ic_read_address,
        input  o_ic_read_done, o_ic_block,
        output i_dc_read_req, i_dc_read_address,
        input  o_dc_read_done, o_dc_block,
        output i_dc_write_valid, i_dc_write_address, i_dc_write_data, i_dc_write_strobe,
        input  o_dc_write_done,
        input  o_mem_read_req, o_mem_read_address,
        output i_mem_read_done, i_mem_block,
        input  o_mem_write_valid, o_mem_write_address, o_mem_write_data, o_mem_write_strobe,
        output i_mem_write_done,
        input  o_busy
    );

endinterface

// File: rtl/riscv_core_mem_arbiter_select.sv
// rtl/riscv_core_mem_arbiter_select.sv - combinational request pick; MEM_ARB_ROUND_ROBIN_EN selects round-robin icache/dcache
module riscv_core_mem_arb_select
    import riscv_core_mem_arb_pkg::*;
(
    input  logic       ic_rd,
    input  logic       dc_rd,
    input  logic       dc_wr,
    input  owner_e     last_owner,
    output arb_state_e pick
);
    // a pending store always goes ahead of a refill to keep store-before-refill order
    arb_state_e dc_pick;
    logic       dc_any;

    assign dc_pick = dc_wr ? WR_DC : RD_DC;
    assign dc_any  = dc_wr || dc_rd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        pick = IDLE;
        if (ic_rd && dc_any)
            pick = (last_owner == OWNER_IC) ? dc_pick : RD_IC;
        else if (dc_any)
            pick = dc_pick;
        else if (ic_rd)
            pick = RD_IC;
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        pick = IDLE;
        if (dc_any)
            pick = dc_pick;
        else if (ic_rd)
            pick = RD_IC;
    end
`endif

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// rtl/riscv_core_mem_arbiter.sv - single-outstanding arbiter of the AXI memory port; MEM_ARB_ROUND_ROBIN_EN enables round-robin
module riscv_core_mem_arbiter
    import riscv_core_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    riscv_core_mem_arbiter_if.master bus
);
    arb_state_e                 state;
    arb_state_e                 next_state;
    arb_state_e                 pick;
    owner_e                     last_owner;
    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [CORE_DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0]      wr_strb;

    riscv_core_mem_arb_select u_select (
        .ic_rd      (bus.i_ic_read_req),
        .dc_rd      (bus.i_dc_read_req),
        .dc_wr      (bus.i_dc_write_valid),
        .last_owner (last_owner),
        .pick       (pick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         next_state = pick;
            RD_IC, RD_DC: if (bus.i_mem_read_done)  next_state = IDLE;
            WR_DC:        if (bus.i_mem_write_done) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // transaction fields are captured only on the grant edge; later request changes are ignored
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else if (state == IDLE) begin
            if (pick == RD_IC)
                rd_addr <= bus.i_ic_read_address;
            else if (pick == RD_DC)
                rd_addr <= bus.i_dc_read_address;
            else if (pick == WR_DC) begin
                wr_addr <= bus.i_dc_write_address;
                wr_data <= bus.i_dc_write_data;
                wr_strb <= bus.i_dc_write_strobe;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_owner <= OWNER_IC;
        else if (state == RD_IC && bus.i_mem_read_done)
            last_owner <= OWNER_IC;
        else if ((state == RD_DC && bus.i_mem_read_done) || (state == WR_DC && bus.i_mem_write_done))
            last_owner <= OWNER_DC;
    end
`else
    assign last_owner = OWNER_IC;
`endif

    always_comb begin
        bus.o_mem_read_req      = is_read(state);
        bus.o_mem_write_valid   = (state == WR_DC);
        bus.o_mem_read_address  = rd_addr;
        bus.o_mem_write_address = wr_addr;
        bus.o_mem_write_data    = wr_data;
        bus.o_mem_write_strobe  = wr_strb;
        bus.o_ic_read_done      = (state == RD_IC) && bus.i_mem_read_done;
        bus.o_dc_read_done      = (state == RD_DC) && bus.i_mem_read_done;
        bus.o_dc_write_done     = (state == WR_DC) && bus.i_mem_write_done;
        bus.o_ic_block          = bus.i_mem_block;
        bus.o_dc_block          = bus.i_mem_block;
        bus.o_busy              = (state != IDLE);
    end

endmodule
